// File: rtl/hsi_pkg.sv
// hsi_pkg: shared write-FSM state encoding and receive status bit positions
package hsi_pkg;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RECV,
        WR_DROP
    } wr_state_e;

    localparam int RX_OK_BIT = 0;

endpackage

// File: rtl/hsi_len_fifo.sv
// hsi_len_fifo: synchronous descriptor FIFO holding committed frame lengths
module hsi_len_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_q, rd_q;
    logic        do_push, do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    always_comb begin
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty_o = wr_q == rd_q;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        head_o  = mem[rd_q[AW-1:0]];
    end

    // Descriptor storage; contents need no reset since empty gates every use
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= din_i;
    end

    // Pointer advance on accepted push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop) rd_q <= rd_q + PW'(1);
        end
    end

endmodule

// File: rtl/hsi_rx_frame_buf.sv
// hsi_rx_frame_buf: commit/rollback receive frame buffer; HSI_RX_STATS_EN adds good/bad frame counters
module hsi_rx_frame_buf
    import hsi_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int MAX_FRAME = 64,
    parameter int LEN_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  q_i,
    input  logic        q_rdy_i,
    input  logic [5:0]  rx_errs_i,
    input  logic        rx_frame_end_i,
    output logic        frame_rdy_o,
    output logic [7:0]  frame_len_o,
    input  logic        rd_en_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    output logic        rd_last_o,
    output logic        drop_pulse_o
`ifdef HSI_RX_STATS_EN
    ,
    output logic [15:0] good_cnt_o,
    output logic [15:0] bad_cnt_o
`endif
);
    localparam int         AW   = $clog2(DEPTH);
    localparam int         PW   = AW + 1;
    localparam logic [7:0] MAXL = 8'(MAX_FRAME);

    logic [7:0]  mem [DEPTH];
    wr_state_e   state_q;
    logic [AW:0] tent_q, comm_q, rd_ptr_q;
    logic [AW:0] tent_inc, tent_d;
    logic [7:0]  cur_len_q, len_d, rd_cnt_q;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q, rd_last_q, drop_q;
    logic        full, ovf, wr_ok, ovf_hit, ends, keep, commit, drop;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_head;
    logic        rd_fire, rd_end;

    // Write-side decisions; a byte arriving with frame end is counted first
    always_comb begin
        full     = (tent_q[AW] != rd_ptr_q[AW]) && (tent_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        ovf      = full || (state_q == WR_RECV && cur_len_q == MAXL);
        wr_ok    = q_rdy_i && state_q != WR_DROP && !ovf;
        ovf_hit  = q_rdy_i && state_q != WR_DROP && ovf;
        tent_inc = tent_q + PW'(1);
        tent_d   = wr_ok ? tent_inc : tent_q;
        len_d    = !wr_ok ? cur_len_q : (state_q == WR_IDLE ? 8'd1 : cur_len_q + 8'd1);
        ends     = rx_frame_end_i && (state_q != WR_IDLE || q_rdy_i);
        keep     = state_q != WR_DROP && !ovf_hit && rx_errs_i[RX_OK_BIT] && !fifo_full;
        commit   = ends && keep;
        drop     = ends && !keep;
        rd_fire  = rd_en_i && !fifo_empty;
        rd_end   = rd_fire && (rd_cnt_q + 8'd1 == fifo_head);
    end

    // Byte store write port; rolled-back bytes are simply overwritten later
    always_ff @(posedge clk) begin
        if (wr_ok) mem[tent_q[AW-1:0]] <= q_i;
    end

    // Write FSM: tentative pointer, frame length, commit/rollback and drop strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WR_IDLE;
            tent_q    <= '0;
            comm_q    <= '0;
            cur_len_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            drop_q <= drop;
            if (ends) begin
                state_q   <= WR_IDLE;
                cur_len_q <= '0;
                tent_q    <= commit ? tent_d : comm_q;
                if (commit) comm_q <= tent_d;
            end else if (ovf_hit) begin
                state_q <= WR_DROP;
            end else if (wr_ok) begin
                state_q   <= WR_RECV;
                tent_q    <= tent_inc;
                cur_len_q <= len_d;
            end
        end
    end

    // Read port: pull head-frame bytes and pop the descriptor on the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            rd_last_q  <= rd_end;
            if (rd_fire) begin
                rd_data_q <= mem[rd_ptr_q[AW-1:0]];
                rd_ptr_q  <= rd_ptr_q + PW'(1);
                rd_cnt_q  <= rd_end ? 8'd0 : rd_cnt_q + 8'd1;
            end
        end
    end

    hsi_len_fifo #(.DEPTH(LEN_DEPTH)) u_len_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (commit),
        .din_i   (len_d),
        .pop_i   (rd_end),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign frame_rdy_o  = !fifo_empty;
    assign frame_len_o  = fifo_empty ? 8'd0 : fifo_head;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_last_o    = rd_last_q;
    assign drop_pulse_o = drop_q;

`ifdef HSI_RX_STATS_EN
    logic [15:0] good_q, bad_q;

    // Saturating counts of committed and discarded frames
    always_ff @(posedge clk) begin
        if (rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            if (commit && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
            if (drop && bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
        end
    end

    assign good_cnt_o = good_q;
    assign bad_cnt_o  = bad_q;
`endif

endmodule

// File: tb/tb_hsi_rx_frame_buf.sv
// tb_hsi_rx_frame_buf: directed self-checking bench for hsi_rx_frame_buf
module tb_hsi_rx_frame_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] q;
    logic       q_rdy;
    logic [5:0] rx_errs;
    logic       rx_frame_end;
    logic       frame_rdy;
    logic [7:0] frame_len;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_last;
    logic       drop_pulse;
`ifdef HSI_RX_STATS_EN
    logic [15:0] good_cnt, bad_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hsi_rx_frame_buf dut (
        .clk            (clk),
        .rst            (rst),
        .q_i            (q),
        .q_rdy_i        (q_rdy),
        .rx_errs_i      (rx_errs),
        .rx_frame_end_i (rx_frame_end),
        .frame_rdy_o    (frame_rdy),
        .frame_len_o    (frame_len),
        .rd_en_i        (rd_en),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .rd_last_o      (rd_last),
        .drop_pulse_o   (drop_pulse)
`ifdef HSI_RX_STATS_EN
        ,
        .good_cnt_o     (good_cnt),
        .bad_cnt_o      (bad_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic fe, input logic [5:0] er);
        q = b;
        q_rdy = 1'b1;
        rx_frame_end = fe;
        rx_errs = er;
        step();
        q_rdy = 1'b0;
        rx_frame_end = 1'b0;
    endtask

    task automatic fend(input logic [5:0] er);
        rx_frame_end = 1'b1;
        rx_errs = er;
        step();
        rx_frame_end = 1'b0;
    endtask

    task automatic frame(input int n, input logic [7:0] base, input logic [5:0] er);
        for (int i = 0; i < n; i++) send(8'(base + i), 1'b0, er);
        fend(er);
    endtask

    task automatic read_frame(input string tag, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            step();
            check({tag, "_data"}, rd_data, 8'(base + i));
            check({tag, "_valid"}, rd_valid, 1);
            check({tag, "_last"}, rd_last, (i == n - 1) ? 1 : 0);
        end
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        q = '0;
        q_rdy = 1'b0;
        rx_errs = '0;
        rx_frame_end = 1'b0;
        rd_en = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_frame_rdy", frame_rdy, 0);
        check("rst_frame_len", frame_len, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_last", rd_last, 0);
        check("rst_drop", drop_pulse, 0);

        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("idle_rd_ignored", rd_valid, 0);

        frame(5, 8'h11, 6'b000001);
        check("f5_rdy", frame_rdy, 1);
        check("f5_len", frame_len, 5);
        check("f5_drop", drop_pulse, 0);
        read_frame("f5", 5, 8'h11);
        check("f5_empty_after", frame_rdy, 0);
        step();
        check("f5_valid_clear", rd_valid, 0);

        frame(3, 8'h21, 6'b000100);
        check("bad_drop", drop_pulse, 1);
        check("bad_rdy", frame_rdy, 0);
        step();
        check("bad_drop_once", drop_pulse, 0);
        frame(2, 8'h31, 6'b000001);
        check("f2_len", frame_len, 2);
        read_frame("f2", 2, 8'h31);

        frame(65, 8'h40, 6'b000001);
        check("ovf_drop", drop_pulse, 1);
        check("ovf_rdy", frame_rdy, 0);
        frame(64, 8'h80, 6'b000001);
        check("max_drop", drop_pulse, 0);
        check("max_len", frame_len, 64);
        read_frame("max", 64, 8'h80);

        for (int k = 0; k < 5; k++) frame(k + 1, 8'(8'h50 + 16 * k), 6'b000001);
        check("fifo_full_drop", drop_pulse, 1);
        check("fifo_len0", frame_len, 1);
        read_frame("q0", 1, 8'h50);
        check("fifo_len1", frame_len, 2);
        read_frame("q1", 2, 8'h60);
        check("fifo_len2", frame_len, 3);
        read_frame("q2", 3, 8'h70);
        check("fifo_len3", frame_len, 4);
        read_frame("q3", 4, 8'h80);
        check("fifo_drained", frame_rdy, 0);

        send(8'h61, 1'b0, 6'b000001);
        send(8'h62, 1'b0, 6'b000001);
        send(8'h63, 1'b0, 6'b000001);
        send(8'h64, 1'b1, 6'b000001);
        check("same_cyc_len", frame_len, 4);
        check("same_cyc_drop", drop_pulse, 0);
        read_frame("same", 4, 8'h61);

        fend(6'b000001);
        check("empty_end_drop", drop_pulse, 0);
        check("empty_end_rdy", frame_rdy, 0);

        send(8'h71, 1'b0, 6'b000001);
        send(8'h72, 1'b0, 6'b000001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_rdy", frame_rdy, 0);
        frame(1, 8'hA5, 6'b000001);
        check("midrst_len", frame_len, 1);
        read_frame("midrst", 1, 8'hA5);
`ifdef HSI_RX_STATS_EN
        check("good_cnt", good_cnt, 1);
        check("bad_cnt", bad_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
